// File: rtl/replay_buffer_param.sv
// Data-link replay buffer: stores TLPs, serialises them onto the link,
// purges on ACK and replays unacknowledged TLPs on NAK or timer expiry.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   wr_en/wr_data          write one TLP (word 0 in the low bits)
//   wr_ready/wr_seq        room available / sequence number of the next write
//   wr_ovf                 pulse: write dropped because the buffer was full
//   acknak_*               received ACK/NAK DLLP
//   tim_out                replay-timer expiry pulse
//   out_ready/out_valid    link handshake; dout/out_last/out_seq carry the word
//   replay_active          the TLP on dout is a retransmission
//   retrain/ack_err        pulses: replay-count rollover / out-of-range ACK/NAK
//   count                  occupied slots
module replay_buffer_param #(
  parameter int DATA_W    = 16,
  parameter int TLP_WORDS = 10,
  parameter int DEPTH     = 8,
  parameter int SEQ_W     = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [TLP_WORDS*DATA_W-1:0]   wr_data,
  output logic                          wr_ready,
  output logic [SEQ_W-1:0]              wr_seq,
  output logic                          wr_ovf,
  input  logic                          acknak_valid,
  input  logic                          acknak_nak,
  input  logic [SEQ_W-1:0]              acknak_seq,
  input  logic                          tim_out,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             dout,
  output logic                          out_last,
  output logic [SEQ_W-1:0]              out_seq,
  output logic                          replay_active,
  output logic                          retrain,
  output logic                          ack_err,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = (TLP_WORDS > 1) ? $clog2(TLP_WORDS) : 1;
  localparam int TW = TLP_WORDS * DATA_W;
  localparam logic [WW-1:0] LAST_W = WW'(TLP_WORDS - 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    SEND_PEND
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]    mem [DEPTH];
  logic [PW-1:0]    head, head_d, tail, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    send_off, send_off_d;
  logic [CW-1:0]    sent_cnt, sent_cnt_d;
  logic [WW-1:0]    word_idx, word_idx_d;
  logic [SEQ_W-1:0] next_seq, next_seq_d;
  logic [1:0]       rnum, rnum_d;
  logic             retrain_d, ack_err_d, wr_ovf_d;

  logic             pend, pend_d;
  logic             wr_acc, fire, trig, purge, bad;
  logic [SEQ_W-1:0] head_seq, n_raw;
  logic [CW-1:0]    n, rem, so1, sc1;
  logic [PW-1:0]    rd_ptr;
  logic [TW-1:0]    rd_tlp;

  // The head sequence number is implied: slots hold consecutive numbers
  // ending just below next_seq.
  assign head_seq      = next_seq - SEQ_W'(count_q);
  assign pend          = (state_q == SEND_PEND);
  assign out_valid     = send_off < count_q;
  assign rd_ptr        = head + send_off[PW-1:0];
  assign rd_tlp        = mem[rd_ptr];
  assign dout          = out_valid
                       ? rd_tlp[DATA_W*int'(word_idx) +: DATA_W]
                       : '0;
  assign out_last      = out_valid && (word_idx == LAST_W);
  assign out_seq       = out_valid
                       ? head_seq + SEQ_W'(send_off)
                       : '0;
  assign replay_active = send_off < sent_cnt;
  assign wr_ready      = count_q < FULL;
  assign wr_seq        = next_seq;
  assign count         = count_q;

  always_comb begin
    word_idx_d = word_idx;
    pend_d     = pend;
    so1        = send_off;
    sc1        = sent_cnt;
    retrain_d  = 1'b0;

    wr_acc   = wr_en && wr_ready;
    wr_ovf_d = wr_en && !wr_ready;
    fire     = out_valid && out_ready;

    if (fire) begin
      if (word_idx == LAST_W) begin
        word_idx_d = '0;
        if (send_off + CW'(1) > sent_cnt)
          sc1 = send_off + CW'(1);
        so1    = pend ? '0 : send_off + CW'(1);
        pend_d = 1'b0;
      end else begin
        word_idx_d = word_idx + WW'(1);
      end
    end

    // Only TLPs sent completely before this edge may be acknowledged.
    n_raw     = acknak_seq - head_seq + SEQ_W'(1);
    bad       = acknak_valid && (n_raw != '0)
             && (n_raw > SEQ_W'(sent_cnt));
    purge     = acknak_valid && (n_raw != '0) && !bad;
    n         = purge ? CW'(n_raw) : '0;
    ack_err_d = bad;

    head_d     = head + PW'(n);
    sent_cnt_d = sc1 - n;
    if (so1 >= n) begin
      send_off_d = so1 - n;
    end else begin
      // The TLP in flight was itself acknowledged; restart at the new head.
      send_off_d = '0;
      word_idx_d = '0;
    end

    rnum_d     = purge ? 2'd0 : rnum;
    rem        = count_q - n;
    count_d    = rem + CW'(wr_acc);
    tail_d     = tail + PW'(wr_acc);
    next_seq_d = next_seq + SEQ_W'(wr_acc);

    trig = tim_out || (acknak_valid && acknak_nak && !bad);
    if (rem == '0) begin
      pend_d = 1'b0;
    end else if (trig) begin
      retrain_d = (rnum_d == 2'd3);
      rnum_d    = rnum_d + 2'd1;
      // Mid-TLP the current TLP finishes first; replay starts after it.
      if (word_idx_d == '0) begin
        send_off_d = '0;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end

    if (pend_d)
      state_d = SEND_PEND;
    else if (send_off_d < count_d)
      state_d = SEND;
    else
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      send_off <= '0;
      sent_cnt <= '0;
      word_idx <= '0;
      next_seq <= '0;
      rnum     <= '0;
      retrain  <= 1'b0;
      ack_err  <= 1'b0;
      wr_ovf   <= 1'b0;
    end else begin
      state_q  <= state_d;
      head     <= head_d;
      tail     <= tail_d;
      count_q  <= count_d;
      send_off <= send_off_d;
      sent_cnt <= sent_cnt_d;
      word_idx <= word_idx_d;
      next_seq <= next_seq_d;
      rnum     <= rnum_d;
      retrain  <= retrain_d;
      ack_err  <= ack_err_d;
      wr_ovf   <= wr_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[tail] <= wr_data;
  end

endmodule

// File: tb/tb_replay_buffer_param.sv
// Self-checking bench for replay_buffer_param: queue-based reference
// model compared every cycle, plus directed literal checks.
module tb_replay_buffer_param;

  localparam int DW = 16;
  localparam int TW = 10;
  localparam int DP = 8;
  localparam int SW = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [TW*DW-1:0] wr_data = '0;
  logic           acknak_valid = 1'b0;
  logic           acknak_nak = 1'b0;
  logic [SW-1:0]  acknak_seq = '0;
  logic           tim_out = 1'b0;
  logic           out_ready = 1'b0;
  logic           wr_ready, wr_ovf, out_valid, out_last;
  logic           replay_active, retrain, ack_err;
  logic [SW-1:0]  wr_seq, out_seq;
  logic [DW-1:0]  dout;
  logic [3:0]     count;

  always #5 clk = ~clk;

  replay_buffer_param #(
    .DATA_W(DW), .TLP_WORDS(TW), .DEPTH(DP), .SEQ_W(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_seq(wr_seq), .wr_ovf(wr_ovf),
    .acknak_valid(acknak_valid), .acknak_nak(acknak_nak),
    .acknak_seq(acknak_seq), .tim_out(tim_out),
    .out_ready(out_ready), .out_valid(out_valid), .dout(dout),
    .out_last(out_last), .out_seq(out_seq),
    .replay_active(replay_active), .retrain(retrain),
    .ack_err(ack_err), .count(count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [TW*DW-1:0] mk(input int t);
    logic [TW*DW-1:0] d;
    for (int j = 0; j < TW; j++)
      d[j*DW +: DW] = 16'(32'h1000 + t*16 + j);
    return d;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [TW*DW-1:0] data;
    int               seq;
  } ent_t;

  ent_t q[$];
  int   m_send, m_word, m_sent, m_rn, m_nseq;
  bit   m_pend, e_retrain, e_ackerr, e_ovf;
  int   t_size0, t_sent0, t_n, t_hseq, t_rem;
  bit   t_bad, t_trig;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_send = 0; m_word = 0; m_sent = 0; m_rn = 0; m_nseq = 0;
      m_pend = 0; e_retrain = 0; e_ackerr = 0; e_ovf = 0;
    end else begin
      e_retrain = 0; e_ackerr = 0; e_ovf = 0;
      t_size0 = q.size();
      t_sent0 = m_sent;
      t_hseq  = (t_size0 > 0) ? q[0].seq : m_nseq;
      if (m_send < t_size0 && out_ready) begin
        if (m_word == TW - 1) begin
          m_word = 0;
          if (m_send + 1 > m_sent) m_sent = m_send + 1;
          m_send = m_pend ? 0 : m_send + 1;
          m_pend = 0;
        end else begin
          m_word++;
        end
      end
      t_n = 0; t_bad = 0;
      if (acknak_valid) begin
        t_n = (int'(acknak_seq) - t_hseq + 1) & 4095;
        if (t_n != 0 && t_n > t_sent0) begin
          t_bad = 1; e_ackerr = 1; t_n = 0;
        end
      end
      if (t_n > 0) begin
        for (int i = 0; i < t_n; i++) void'(q.pop_front());
        m_sent -= t_n;
        if (m_send >= t_n) m_send -= t_n;
        else begin m_send = 0; m_word = 0; end
        m_rn = 0;
      end
      if (wr_en) begin
        if (t_size0 < DP) begin
          q.push_back('{data: wr_data, seq: m_nseq});
          m_nseq = (m_nseq + 1) & 4095;
        end else e_ovf = 1;
      end
      t_trig = tim_out || (acknak_valid && acknak_nak && !t_bad);
      t_rem  = t_size0 - t_n;
      if (t_rem == 0) m_pend = 0;
      else if (t_trig) begin
        if (m_rn == 3) begin m_rn = 0; e_retrain = 1; end
        else m_rn++;
        if (m_word == 0) begin m_send = 0; m_pend = 0; end
        else m_pend = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int obs_last = 0, obs_retrain = 0, obs_ackerr = 0;
  bit x_valid;

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      x_valid = m_send < q.size();
      chk("out_valid", out_valid, x_valid);
      chk("dout", dout, x_valid ? q[m_send].data[m_word*DW +: DW] : 0);
      chk("out_last", out_last, x_valid && m_word == TW - 1);
      chk("out_seq", out_seq, x_valid ? q[m_send].seq : 0);
      chk("replay_active", replay_active, m_send < m_sent);
      chk("count", count, q.size());
      chk("wr_ready", wr_ready, q.size() < DP);
      chk("wr_seq", wr_seq, m_nseq);
      chk("retrain", retrain, e_retrain);
      chk("ack_err", ack_err, e_ackerr);
      chk("wr_ovf", wr_ovf, e_ovf);
      if (out_last && out_ready) obs_last++;
      if (retrain) obs_retrain++;
      if (ack_err) obs_ackerr++;
    end
  end

  // ---------------- stimulus ----------------
  int tnum = 0;

  task automatic do_reset();
    rst = 1; wr_en = 0; acknak_valid = 0; tim_out = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_seq", out_seq, 0);
    chk("rst_replay_active", replay_active, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_wr_seq", wr_seq, 0);
    chk("rst_count", count, 0);
    chk("rst_pulses", {retrain, ack_err, wr_ovf}, 0);
    rst = 0; tnum = 0;
  endtask

  task automatic write_n(input int k);
    for (int i = 0; i < k; i++) begin
      wr_en = 1; wr_data = mk(tnum); tnum++;
      @(negedge clk);
    end
    wr_en = 0;
  endtask

  task automatic acknak(input bit nak, input int s);
    acknak_valid = 1; acknak_nak = nak; acknak_seq = SW'(s);
    @(negedge clk);
    acknak_valid = 0;
  endtask

  task automatic pulse_tim();
    tim_out = 1;
    @(negedge clk);
    tim_out = 0;
  endtask

  int written, ackerr0, cyc;

  initial begin
    @(negedge clk);
    // basic transmit of three TLPs
    do_reset();
    out_ready = 1;
    wr_en = 1; wr_data = mk(0); tnum = 1;
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    chk("first_dout", dout, 16'h1000);
    chk("first_seq", out_seq, 0);
    write_n(2);
    chk("count3", count, 3);
    obs_last = 0;
    repeat (30) @(negedge clk);
    chk("lasts", obs_last, 3);
    chk("idle_after30", out_valid, 0);
    // ACK purge, duplicate, out of range
    acknak(0, 1);
    chk("ack1_count", count, 1);
    acknak(0, 1);
    chk("dup_count", count, 1);
    chk("dup_noerr", ack_err, 0);
    acknak(0, 5);
    chk("bad_err", ack_err, 1);
    chk("bad_count", count, 1);

    // NAK replay then timer during word 4
    do_reset();
    out_ready = 1;
    write_n(3);
    repeat (32) @(negedge clk);
    acknak(1, 0);
    chk("nak_count", count, 2);
    chk("nak_seq", out_seq, 1);
    chk("nak_replay", replay_active, 1);
    chk("nak_dout", dout, 16'h1010);
    repeat (4) @(negedge clk);
    chk("w4_dout", dout, 16'h1014);
    pulse_tim();
    chk("w5_dout", dout, 16'h1015);
    repeat (5) @(negedge clk);
    chk("rep_seq", out_seq, 1);
    chk("rep_dout", dout, 16'h1010);
    chk("rep_active", replay_active, 1);
    repeat (30) @(negedge clk);

    // retrain after four replays, cleared by forward progress
    do_reset();
    out_ready = 1;
    write_n(2);
    repeat (25) @(negedge clk);
    obs_retrain = 0;
    for (int k = 0; k < 4; k++) begin
      pulse_tim();
      @(negedge clk);
      if (k == 2) chk("no_retrain3", obs_retrain, 0);
    end
    chk("retrain4", obs_retrain, 1);
    repeat (40) @(negedge clk);
    acknak(0, 0);
    chk("ack_after_rt", count, 1);
    for (int k = 0; k < 3; k++) begin
      pulse_tim();
      @(negedge clk);
    end
    chk("rn_cleared", obs_retrain, 1);
    repeat (40) @(negedge clk);

    // fill and overflow
    do_reset();
    out_ready = 0;
    write_n(8);
    chk("full_ready", wr_ready, 0);
    chk("full_count", count, 8);
    wr_en = 1; wr_data = mk(tnum);
    @(negedge clk);
    wr_en = 0;
    chk("ovf", wr_ovf, 1);
    chk("ovf_count", count, 8);

    // stream across the sequence wrap
    out_ready = 1;
    ackerr0 = obs_ackerr;
    written = 0;
    for (cyc = 0; cyc < 60000; cyc++) begin
      if (written == 4100 && q.size() == 0) break;
      wr_en = (written < 4100) && (q.size() < DP);
      if (wr_en) begin
        wr_data = mk(tnum); tnum++; written++;
      end
      acknak_valid = m_sent > 0;
      acknak_nak = 0;
      acknak_seq = (m_sent > 0) ? SW'(q[m_sent-1].seq) : '0;
      @(negedge clk);
    end
    wr_en = 0; acknak_valid = 0;
    chk("wrap_budget", cyc < 60000, 1);
    @(negedge clk);
    chk("wrap_seq", wr_seq, 12);
    chk("wrap_count", count, 0);
    chk("wrap_ackerr", obs_ackerr - ackerr0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
